tcm_loader: RTL and testbench



---
 rtl/tcm_loader_pkg.sv | 27 ++
 rtl/tcm_loader_shift.sv | 28 ++
 rtl/tcm_loader.sv | 168 ++++++++++++++++
 tb/tb_tcm_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tcm_loader_pkg.sv
// Shared types and constants for the TCM loader: FSM states, command codes,
// default status bytes and the word-address range helper.
package tcm_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_PC   = 3'd4,
    S_RESP = 3'd5
  } state_t;

  localparam logic [7:0] CMD_WRITE_I = 8'h01;
  localparam logic [7:0] CMD_WRITE_D = 8'h02;
  localparam logic [7:0] CMD_RUN     = 8'h03;
  localparam logic [7:0] CMD_HALT    = 8'h04;

  localparam logic [7:0] ACK_DEF = 8'hA5;
  localparam logic [7:0] NAK_DEF = 8'hEE;

  // True when a word address lies inside a memory of 2^aw words.
  function automatic logic addr_ok(input logic [29:0] addr, input int aw);
    return (addr >> aw) == 30'd0;
  endfunction

endpackage

// File: rtl/tcm_loader_shift.sv
// Little-endian 32-bit byte assembler shared by every multi-byte field.
// word is the value including the byte on din, valid together with done.
module tcm_loader_shift (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        done
);

  logic [31:0] sr;
  logic [1:0]  cnt;

  assign word = {din, sr[31:8]};
  assign done = en && (cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= 32'd0;
      cnt <= 2'd0;
    end else if (en) begin
      sr  <= word;
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/tcm_loader.sv
// Host-side TCM loader: decodes framed byte commands, writes ITCM/DTCM words,
// sets the boot PC and controls cpu_reset, answering each frame with one status byte.
//
// state  | meaning
// S_IDLE | wait for and decode a command byte
// S_ADDR | collect 4-byte start byte address
// S_LEN  | collect 4-byte word count
// S_DATA | collect 4 bytes per word, write each completed word
// S_PC   | collect 4-byte boot PC
// S_RESP | present status byte until the host accepts it
module tcm_loader
  import tcm_loader_pkg::*;
#(
  parameter int         IMEM_AW = 14,
  parameter int         DMEM_AW = 14,
  parameter logic [7:0] ACK     = ACK_DEF,
  parameter logic [7:0] NAK     = NAK_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_we_i,
  output logic        mem_we_d,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic [31:0] reset_pc,
  output logic        busy
);

  state_t      state;
  logic        is_d;
  logic        err;
  logic [29:0] waddr;
  logic [31:0] len;

  logic        acc;
  logic        field_en;
  logic [31:0] field_word;
  logic        field_done;
  logic        wr_ok;

  assign rx_ready = (state != S_RESP);
  assign busy     = (state != S_IDLE);
  assign acc      = rx_valid && rx_ready;
  assign field_en = acc && (state inside {S_ADDR, S_LEN, S_DATA, S_PC});

  // Writes are only legal while the cpu is held and the word is inside the target TCM.
  assign wr_ok = cpu_reset && addr_ok(waddr, is_d ? DMEM_AW : IMEM_AW);

  tcm_loader_shift u_shift (
    .clk  (clk),
    .reset(reset),
    .en   (field_en),
    .din  (rx_data),
    .word (field_word),
    .done (field_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      is_d      <= 1'b0;
      err       <= 1'b0;
      waddr     <= 30'd0;
      len       <= 32'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
      mem_we_i  <= 1'b0;
      mem_we_d  <= 1'b0;
      mem_addr  <= 30'd0;
      mem_wdata <= 32'd0;
      cpu_reset <= 1'b1;
      reset_pc  <= 32'd0;
    end else begin
      mem_we_i <= 1'b0;
      mem_we_d <= 1'b0;
      case (state)
        S_IDLE: begin
          if (acc) begin
            case (rx_data)
              CMD_WRITE_I: begin
                is_d  <= 1'b0;
                state <= S_ADDR;
              end
              CMD_WRITE_D: begin
                is_d  <= 1'b1;
                state <= S_ADDR;
              end
              CMD_RUN: state <= S_PC;
              CMD_HALT: begin
                cpu_reset <= 1'b1;
                tx_valid  <= 1'b1;
                tx_data   <= ACK;
                state     <= S_RESP;
              end
              default: begin
                tx_valid <= 1'b1;
                tx_data  <= NAK;
                state    <= S_RESP;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (field_done) begin
            waddr <= field_word[31:2];
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (field_done) begin
            len <= field_word;
            if (field_word == 32'd0) begin
              tx_valid <= 1'b1;
              tx_data  <= err ? NAK : ACK;
              state    <= S_RESP;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (field_done) begin
            if (wr_ok) begin
              mem_we_i  <= !is_d;
              mem_we_d  <= is_d;
              mem_addr  <= waddr;
              mem_wdata <= field_word;
            end else begin
              err <= 1'b1;
            end
            waddr <= waddr + 30'd1;
            len   <= len - 32'd1;
            if (len == 32'd1) begin
              tx_valid <= 1'b1;
              tx_data  <= (err || !wr_ok) ? NAK : ACK;
              state    <= S_RESP;
            end
          end
        end
        S_PC: begin
          if (field_done) begin
            reset_pc  <= field_word;
            cpu_reset <= 1'b0;
            tx_valid  <= 1'b1;
            tx_data   <= ACK;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            err      <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_loader.sv
// Directed self-checking bench for tcm_loader: frames are driven byte by byte
// and strobes, status bytes and cpu control are compared with hand-computed values.
module tb_tcm_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_we_i;
  logic        mem_we_d;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic [31:0] reset_pc;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int wi_cnt   = 0;
  int wd_cnt   = 0;

  always #5 clk = ~clk;

  tcm_loader dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .mem_we_i (mem_we_i),
    .mem_we_d (mem_we_d),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .reset_pc (reset_pc),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (mem_we_i) wi_cnt++;
    if (mem_we_d) wd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns at posedge+#1 of the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic get_status(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(exp));
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_reset_pc", reset_pc, 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'({mem_we_i, mem_we_d}), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // WRITE_I addr 0, two words
    send_byte(8'h01);
    send_word(32'h0000_0000);
    send_word(32'h0000_0002);
    send_word(32'h0000_0013);
    chk("wi0_we", 32'(mem_we_i), 32'd1);
    chk("wi0_addr", 32'(mem_addr), 32'd0);
    chk("wi0_data", mem_wdata, 32'h0000_0013);
    send_byte(8'h93);
    chk("wi0_pulse_one_cycle", 32'(mem_we_i), 32'd0);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    chk("wi1_we", 32'(mem_we_i), 32'd1);
    chk("wi1_addr", 32'(mem_addr), 32'd1);
    chk("wi1_data", mem_wdata, 32'h0010_0093);
    chk("wi_tx_early", 32'(tx_valid), 32'd1);
    chk("wi_rx_ready_resp", 32'(rx_ready), 32'd0);
    get_status("wi_status", 8'hA5);
    chk("wi_count", 32'(wi_cnt), 32'd2);

    // WRITE_D len 0: status right after the 9th byte, no strobes
    send_byte(8'h02);
    send_word(32'h0000_0100);
    send_word(32'h0000_0000);
    chk("d0_tx_valid", 32'(tx_valid), 32'd1);
    chk("d0_tx_data", 32'(tx_data), 32'hA5);
    get_status("d0_status", 8'hA5);
    chk("d0_count", 32'(wd_cnt), 32'd0);

    // WRITE_I straddling the top of ITCM: first word ok, second out of range
    send_byte(8'h01);
    send_word(32'h0000_FFFC);
    send_word(32'h0000_0002);
    send_word(32'h1111_1111);
    chk("top_we", 32'(mem_we_i), 32'd1);
    chk("top_addr", 32'(mem_addr), 32'h3FFF);
    send_word(32'h2222_2222);
    chk("top_over_we", 32'(mem_we_i), 32'd0);
    get_status("top_status", 8'hEE);
    chk("top_count", 32'(wi_cnt), 32'd3);

    // RUN, then write while running, then HALT
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("run_before", 32'(cpu_reset), 32'd1);
    send_byte(8'h80);
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run_pc", reset_pc, 32'h8000_0000);
    get_status("run_status", 8'hA5);
    send_byte(8'h02);
    send_word(32'h0000_0000);
    send_word(32'h0000_0001);
    send_word(32'hCAFE_F00D);
    chk("running_we", 32'(mem_we_d), 32'd0);
    get_status("running_status", 8'hEE);
    chk("running_count", 32'(wd_cnt), 32'd0);
    send_byte(8'h04);
    chk("halt_cpu_reset", 32'(cpu_reset), 32'd1);
    get_status("halt_status", 8'hA5);

    // Unknown command with host backpressure
    send_byte(8'h7F);
    for (int i = 0; i < 10; i++) begin
      chk("bp_tx_valid", 32'(tx_valid), 32'd1);
      chk("bp_tx_data", 32'(tx_data), 32'hEE);
      chk("bp_rx_ready", 32'(rx_ready), 32'd0);
      @(posedge clk); #1;
    end
    get_status("bad_status", 8'hEE);

    // Reset mid-frame after 6 data bytes (one full word already written)
    send_byte(8'h02);
    send_word(32'h0000_0000);
    send_word(32'h0000_0004);
    send_word(32'h0102_0304);
    send_byte(8'h05);
    send_byte(8'h06);
    chk("mid_count_before", 32'(wd_cnt), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_tx_data", 32'(tx_data), 32'd0);
    chk("mid_addr", 32'(mem_addr), 32'd0);
    chk("mid_wdata", mem_wdata, 32'd0);
    chk("mid_pc", reset_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_count_after", 32'(wd_cnt), 32'd1);
    send_byte(8'h02);
    send_word(32'h0000_0008);
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    chk("post_we", 32'(mem_we_d), 32'd1);
    chk("post_addr", 32'(mem_addr), 32'd2);
    chk("post_data", mem_wdata, 32'hDEAD_BEEF);
    get_status("post_status", 8'hA5);
    chk("post_count", 32'(wd_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
